// File: rtl/vregfile_scalar_2r1w.sv
// Scalar register file for the vector unit: two registered read ports, one write port, r0 hardwired to zero.
// Define VREGFILE_SCALAR_BYPASS_EN for write-first reads when a port reads the register being written.
module vregfile_scalar_2r1w #(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 32,
    parameter int LOG2NUMREGS = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [LOG2NUMREGS-1:0] a_reg,
    input  logic                   a_en,
    output logic [WIDTH-1:0]       a_readdataout,
    input  logic [LOG2NUMREGS-1:0] b_reg,
    input  logic                   b_en,
    output logic [WIDTH-1:0]       b_readdataout,
    input  logic [LOG2NUMREGS-1:0] c_reg,
    input  logic [WIDTH-1:0]       c_writedatain,
    input  logic                   c_we,
    output logic                   busy
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [LOG2NUMREGS-1:0] FIRST_PTR = LOG2NUMREGS'(1);
    localparam logic [LOG2NUMREGS-1:0] LAST_PTR  = LOG2NUMREGS'(NUMREGS - 1);

    logic [0:0]             state;
    logic [LOG2NUMREGS-1:0] clear_ptr;
    logic [WIDTH-1:0]       mem [NUMREGS];
    logic                   run;
    logic                   wr_en;
    logic [WIDTH-1:0]       a_word;
    logic [WIDTH-1:0]       b_word;

    assign run   = (state == ST_RUN);
    assign busy  = ~run;
    assign wr_en = run & c_we & (c_reg != '0);

    // Clear sequencer: sweeps r1..rN-1 once after every reset; r0 is never stored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_CLEAR;
            clear_ptr <= FIRST_PTR;
        end else if (state == ST_CLEAR) begin
            clear_ptr <= clear_ptr + FIRST_PTR;
            if (clear_ptr == LAST_PTR) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clear_ptr] <= '0;
        end else if (wr_en) begin
            mem[c_reg] <= c_writedatain;
        end
    end

    always_comb begin
        a_word = mem[a_reg];
        b_word = mem[b_reg];
`ifdef VREGFILE_SCALAR_BYPASS_EN
        if (wr_en && (a_reg == c_reg)) begin
            a_word = c_writedatain;
        end
        if (wr_en && (b_reg == c_reg)) begin
            b_word = c_writedatain;
        end
`endif
        // Zero mux last so r0 wins over any bypass and never exposes unwritten storage.
        if (a_reg == '0) begin
            a_word = '0;
        end
        if (b_reg == '0) begin
            b_word = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_readdataout <= '0;
            b_readdataout <= '0;
        end else if (!run) begin
            a_readdataout <= '0;
            b_readdataout <= '0;
        end else begin
            if (a_en) begin
                a_readdataout <= a_word;
            end
            if (b_en) begin
                b_readdataout <= b_word;
            end
        end
    end

endmodule

// File: doc/vregfile_scalar_2r1w.md
Name: vregfile_scalar_2r1w

Overview:
Parametrised scalar register file for the vector unit, successor to the single-read-port scalar file. It provides two independent synchronous read ports (a, b) and one write port (c), with register 0 hardwired to zero. A post-reset clear sequencer zeroes the whole array, so the contents are defined after reset. An optional read-during-write bypass is available. It sits beside the vector lanes and supplies scalar operands to vector-scalar instructions.

Parameters:
WIDTH, 32, data width of each register in bits
NUMREGS, 32, number of registers; must equal 2**LOG2NUMREGS and be at least 2
LOG2NUMREGS, 5, register address width

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous active-low reset
a_reg  input  LOG2NUMREGS  read port A address
a_en  input  1  read port A enable
a_readdataout  output  WIDTH  read port A data, registered
b_reg  input  LOG2NUMREGS  read port B address
b_en  input  1  read port B enable
b_readdataout  output  WIDTH  read port B data, registered
c_reg  input  LOG2NUMREGS  write address
c_writedatain  input  WIDTH  write data
c_we  input  1  write enable
busy  output  1  high while the clear sequence runs; the file ignores all accesses while it is high

Behaviour:
- Reset:
  - The reset is asynchronous and active-low; resetn low takes effect immediately, without waiting for a clock edge.
  - While resetn is low: a_readdataout=0, b_readdataout=0, busy=1, FSM in CLEAR, clear_ptr=1.
  - The storage array itself has no reset; the CLEAR state initialises it.
- FSM, two states:
  - CLEAR: each cycle, write 0 to mem[clear_ptr] and increment clear_ptr. When clear_ptr==NUMREGS-1, write that entry and move to RUN on the next edge. CLEAR therefore lasts NUMREGS-1 cycles after reset release (31 cycles at the default).
  - RUN: busy=0. The FSM stays in RUN until the next reset.
  - A reset asserted mid-CLEAR or mid-RUN returns the FSM to CLEAR with clear_ptr=1 and restarts the full sweep.
- While busy=1:
  - c_we is ignored.
  - a_en and b_en are ignored; both output registers hold 0.
- Write (RUN only): mem[c_reg] <= c_writedatain at the edge when c_we=1 and c_reg!=0. A write to register 0 is discarded.
- Read (RUN only), per port, ports fully independent:
  - At the edge where x_en=1, x_readdataout <= (x_reg==0) ? 0 : mem[x_reg].
  - Latency: address and enable are sampled at edge N; data is valid after edge N and stays valid until the next enabled read.
  - x_en=0: x_readdataout holds its previous value regardless of changes on x_reg.
- Both ports may read the same address in the same cycle; both return identical data.
- Same-address read and write in the same cycle: the read returns the old stored value (OLD_DATA), unless the optional feature below is compiled in.
- Register 0 reads 0 on both ports at all times, including a same-cycle write to address 0.
- No X may propagate to an output after the clear sequence completes.

Optional Feature:
VREGFILE_SCALAR_BYPASS_EN
- Defined: when c_we=1, c_reg!=0 and x_reg==c_reg in the same RUN cycle with x_en=1, x_readdataout takes c_writedatain (write-first). This applies to each port independently. Register 0 still reads 0.
- Undefined: OLD_DATA as above. The macro adds no ports and changes no other behaviour.

Test Plan:
- Reset clear: hold resetn low 3 cycles, then release -> busy=1 for exactly 31 cycles, then 0. Reading all 32 registers on A and B returns 0x00000000.
- Basic write/read: write 0xDEADBEEF to r5; next cycle a_reg=5, a_en=1 and b_reg=5, b_en=1 -> both outputs 0xDEADBEEF one cycle later.
- r0 protection: write 0x00001234 to r0, then read r0 on A -> 0x00000000.
- Read-during-write: r7 holds 0x00000011; in one cycle write 0xAAAA5555 to r7 and read r7 on A -> 0x00000011 without the macro, 0xAAAA5555 with it. A read of r7 on the following cycle returns 0xAAAA5555 in both builds.
- Enable hold: read r5 (0xDEADBEEF) on A, then a_en=0 and a_reg=7 for 4 cycles -> a_readdataout stays 0xDEADBEEF.
- Reset mid-operation: write 0x5A5A5A5A to r9, pulse resetn low mid-cycle, and drive c_we=1 to r9 with 0xFFFFFFFF during busy:
  - outputs go to 0 immediately;
  - busy reasserts for 31 cycles;
  - a read of r9 afterwards returns 0x00000000.
